// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback sequencer.
package wb_pkg;

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } wb_state_e;

   // Link address offset for JAL/JALR.
   localparam int PC_STEP = 4;
   // Bit mask of the target bits that JALR clears.
   localparam int JALR_LSB_MASK = 1;
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_load_timer.sv
// Load watchdog: counts cycles spent waiting for load data.
// expired is high while the count sits at LOAD_TIMEOUT-1.
module wb_load_timer
   import wb_pkg::*;
#(
   parameter int LOAD_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

   logic [CW-1:0] count;

   assign expired = (count == CW'(LOAD_TIMEOUT - 1));

   // Count up while enabled, holding at the terminal value.
   always_ff @(posedge clk) begin
      if (rst || clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + CW'(1);
   end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback sequencer: owns the register-file write port, waits for
// load data, issues JAL/JALR redirects and aborts loads that time out.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
//
// state     | meaning
// IDLE      | ready to accept a retiring instruction
// LOAD_WAIT | load accepted, waiting for ld_valid or the watchdog
module wb_ctrl
   import wb_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int LOAD_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [4:0]      ex_rd,
   input  logic            ex_reg_write,
   input  logic            ex_mem_to_reg,
   input  logic            ex_jal,
   input  logic            ex_jalr,
   input  logic [XLEN-1:0] ex_alu_out,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ld_valid,
   input  logic [XLEN-1:0] ld_data,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            pc_redir,
   output logic [XLEN-1:0] pc_target,
   output logic            ld_timeout,
   output logic [31:0]     retire_cnt
);

   wb_state_e state, state_nxt;

   logic [4:0]      ld_rd;
   logic            accept, is_jump, is_load;
   logic            tmr_expired;
   logic            rf_we_d, pc_redir_d, ld_timeout_d;
   logic [4:0]      rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_d, pc_target_d;

   assign ex_ready = (state == IDLE);
   assign accept   = ex_valid && ex_ready;
   assign is_jump  = ex_jal || ex_jalr;
   assign is_load  = ex_mem_to_reg && !is_jump;

   wb_load_timer #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept && is_load),
      .enable  ((state == LOAD_WAIT) && !ld_valid),
      .expired (tmr_expired)
   );

   // State, latched load destination and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ld_rd      <= REG_ZERO;
         rf_we      <= 1'b0;
         rf_waddr   <= REG_ZERO;
         rf_wdata   <= '0;
         pc_redir   <= 1'b0;
         pc_target  <= '0;
         ld_timeout <= 1'b0;
      end else begin
         state      <= state_nxt;
         if (accept && is_load)
            ld_rd <= ex_rd;
         rf_we      <= rf_we_d;
         rf_waddr   <= rf_waddr_d;
         rf_wdata   <= rf_wdata_d;
         pc_redir   <= pc_redir_d;
         pc_target  <= pc_target_d;
         ld_timeout <= ld_timeout_d;
      end
   end

   // Next state: enter LOAD_WAIT on a load, leave on data or timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept && is_load) state_nxt = LOAD_WAIT;
         LOAD_WAIT: if (ld_valid || tmr_expired) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Next output values; data outputs hold unless a new result lands.
   always_comb begin
      rf_we_d      = 1'b0;
      pc_redir_d   = 1'b0;
      ld_timeout_d = 1'b0;
      rf_waddr_d   = rf_waddr;
      rf_wdata_d   = rf_wdata;
      pc_target_d  = pc_target;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_jump) begin
                  pc_redir_d  = 1'b1;
                  pc_target_d = ex_jalr ? (ex_alu_out & ~XLEN'(JALR_LSB_MASK)) : ex_alu_out;
                  rf_we_d     = (ex_rd != REG_ZERO);
                  rf_waddr_d  = ex_rd;
                  rf_wdata_d  = ex_pc + XLEN'(PC_STEP);
               end else if (!ex_mem_to_reg && ex_reg_write) begin
                  rf_we_d    = (ex_rd != REG_ZERO);
                  rf_waddr_d = ex_rd;
                  rf_wdata_d = ex_alu_out;
               end
            end
         end
         LOAD_WAIT: begin
            // Data arriving on the expiry cycle still wins.
            if (ld_valid) begin
               rf_we_d    = (ld_rd != REG_ZERO);
               rf_waddr_d = ld_rd;
               rf_wdata_d = ld_data;
            end else if (tmr_expired) begin
               ld_timeout_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_q;
   logic        retire;

   assign retire = (accept && !is_load) || ((state == LOAD_WAIT) && ld_valid);

   // Count completed retires; aborted loads are not counted.
   always_ff @(posedge clk) begin
      if (rst)
         retire_q <= '0;
      else if (retire)
         retire_q <= retire_q + 32'd1;
   end

   assign retire_cnt = retire_q;
`else
   assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl with LOAD_TIMEOUT=4.
module tb_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_to_reg, ex_jal, ex_jalr;
   logic [31:0] ex_alu_out, ex_pc;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        pc_redir;
   logic [31:0] pc_target;
   logic        ld_timeout;
   logic [31:0] retire_cnt;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_ret = 32'd0;

   always #5 clk = ~clk;

   wb_ctrl #(.XLEN(32), .LOAD_TIMEOUT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_ready      (ex_ready),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_to_reg (ex_mem_to_reg),
      .ex_jal        (ex_jal),
      .ex_jalr       (ex_jalr),
      .ex_alu_out    (ex_alu_out),
      .ex_pc         (ex_pc),
      .ld_valid      (ld_valid),
      .ld_data       (ld_data),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .pc_redir      (pc_redir),
      .pc_target     (pc_target),
      .ld_timeout    (ld_timeout),
      .retire_cnt    (retire_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=0x%08h want=0x%08h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retired();
`ifdef WB_RETIRE_CNT_EN
      exp_ret = exp_ret + 32'd1;
`endif
   endtask

   task automatic idle_inputs();
      ex_valid = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
      ex_jal = 0; ex_jalr = 0; ex_alu_out = 0; ex_pc = 0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic rw, input logic m2r,
                        input logic jal, input logic jalr,
                        input logic [31:0] alu, input logic [31:0] pc);
      ex_valid = 1; ex_rd = rd; ex_reg_write = rw; ex_mem_to_reg = m2r;
      ex_jal = jal; ex_jalr = jalr; ex_alu_out = alu; ex_pc = pc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      rst = 1; ld_valid = 0; ld_data = 0;
      idle_inputs();
      tick(); tick();
      rst = 0;
      chk("rst_we",      32'(rf_we), 32'd0);
      chk("rst_redir",   32'(pc_redir), 32'd0);
      chk("rst_tmo",     32'(ld_timeout), 32'd0);
      chk("rst_waddr",   32'(rf_waddr), 32'd0);
      chk("rst_wdata",   rf_wdata, 32'd0);
      chk("rst_target",  pc_target, 32'd0);
      chk("rst_ready",   32'(ex_ready), 32'd1);
      chk("rst_retire",  retire_cnt, 32'd0);

      // ALU write
      issue(5'd5, 1, 0, 0, 0, 32'h1234, 32'h0);
      tick(); idle_inputs(); retired();
      chk("alu_we",    32'(rf_we), 32'd1);
      chk("alu_waddr", 32'(rf_waddr), 32'd5);
      chk("alu_wdata", rf_wdata, 32'h1234);
      chk("alu_redir", 32'(pc_redir), 32'd0);
      chk("alu_ready", 32'(ex_ready), 32'd1);
      tick();
      chk("alu_pulse", 32'(rf_we), 32'd0);
      chk("alu_hold",  rf_wdata, 32'h1234);

      // JALR, then back-to-back JAL to x0, then jal+jalr+mem_to_reg
      issue(5'd1, 1, 0, 0, 1, 32'h2003, 32'h100);
      tick(); retired();
      chk("jalr_redir",  32'(pc_redir), 32'd1);
      chk("jalr_target", pc_target, 32'h2002);
      chk("jalr_we",     32'(rf_we), 32'd1);
      chk("jalr_waddr",  32'(rf_waddr), 32'd1);
      chk("jalr_wdata",  rf_wdata, 32'h104);
      issue(5'd0, 1, 0, 1, 0, 32'h3001, 32'h200);
      tick(); retired();
      chk("jal0_redir",  32'(pc_redir), 32'd1);
      chk("jal0_target", pc_target, 32'h3001);
      chk("jal0_we",     32'(rf_we), 32'd0);
      issue(5'd3, 0, 1, 1, 1, 32'h4001, 32'hFFFF_FFFC);
      tick(); idle_inputs(); retired();
      chk("both_target", pc_target, 32'h4000);
      chk("both_wdata",  rf_wdata, 32'h0);
      chk("both_we",     32'(rf_we), 32'd1);
      chk("both_ready",  32'(ex_ready), 32'd1);
      chk("retire_a",    retire_cnt, exp_ret);

      // No-op retire and ld_valid ignored in IDLE
      issue(5'd4, 0, 0, 0, 0, 32'h55, 32'h0);
      ld_valid = 1; ld_data = 32'h9999;
      tick(); idle_inputs(); ld_valid = 0; retired();
      chk("nop_we",    32'(rf_we), 32'd0);
      chk("nop_redir", 32'(pc_redir), 32'd0);
      chk("nop_ready", 32'(ex_ready), 32'd1);
      chk("nop_wdata", rf_wdata, 32'h0);

      // Load with data after three wait cycles, reg_write clear
      issue(5'd7, 0, 1, 0, 0, 32'h0, 32'h0);
      tick(); idle_inputs();
      chk("ld_ready0", 32'(ex_ready), 32'd0);
      tick();
      chk("ld_ready1", 32'(ex_ready), 32'd0);
      tick();
      chk("ld_ready2", 32'(ex_ready), 32'd0);
      ld_valid = 1; ld_data = 32'hDEADBEEF;
      tick(); ld_valid = 0; retired();
      chk("ld_we",    32'(rf_we), 32'd1);
      chk("ld_waddr", 32'(rf_waddr), 32'd7);
      chk("ld_wdata", rf_wdata, 32'hDEADBEEF);
      chk("ld_tmo",   32'(ld_timeout), 32'd0);
      chk("ld_ready", 32'(ex_ready), 32'd1);
      chk("retire_b", retire_cnt, exp_ret);

      // Timeout: four LOAD_WAIT cycles, no data
      issue(5'd9, 1, 1, 0, 0, 32'h0, 32'h0);
      tick(); idle_inputs();
      for (int i = 0; i < 3; i++) begin
         chk("to_wait_tmo",   32'(ld_timeout), 32'd0);
         chk("to_wait_ready", 32'(ex_ready), 32'd0);
         tick();
      end
      chk("to_wait_tmo",   32'(ld_timeout), 32'd0);
      tick();
      chk("to_tmo",    32'(ld_timeout), 32'd1);
      chk("to_we",     32'(rf_we), 32'd0);
      chk("to_ready",  32'(ex_ready), 32'd1);
      chk("to_retire", retire_cnt, exp_ret);
      tick();
      chk("to_pulse",  32'(ld_timeout), 32'd0);

      // ld_valid on the expiry cycle: data wins
      issue(5'd10, 0, 1, 0, 0, 32'h0, 32'h0);
      tick(); idle_inputs();
      tick(); tick(); tick();
      ld_valid = 1; ld_data = 32'hA5A5_0F0F;
      tick(); ld_valid = 0; retired();
      chk("edge_we",    32'(rf_we), 32'd1);
      chk("edge_waddr", 32'(rf_waddr), 32'd10);
      chk("edge_wdata", rf_wdata, 32'hA5A5_0F0F);
      chk("edge_tmo",   32'(ld_timeout), 32'd0);
      chk("retire_c",   retire_cnt, exp_ret);

      // Reset mid-load, then stray ld_valid
      issue(5'd11, 0, 1, 0, 0, 32'h0, 32'h0);
      tick(); idle_inputs();
      tick();
      rst = 1;
      tick();
      rst = 0; ld_valid = 1; ld_data = 32'h5555_5555;
      tick(); ld_valid = 0;
      chk("mr_we",     32'(rf_we), 32'd0);
      chk("mr_waddr",  32'(rf_waddr), 32'd0);
      chk("mr_wdata",  rf_wdata, 32'd0);
      chk("mr_target", pc_target, 32'd0);
      chk("mr_redir",  32'(pc_redir), 32'd0);
      chk("mr_tmo",    32'(ld_timeout), 32'd0);
      chk("mr_ready",  32'(ex_ready), 32'd1);
      chk("mr_retire", retire_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
Writeback sequencer for the multi-cycle RV32I core. Accepts one retiring instruction per handshake from execute and owns the single register-file write port. Waits for multi-cycle load data and emits PC redirects for JAL/JALR. All outputs are registered, with a load-timeout watchdog.

Parameters:
XLEN, 32, datapath width.
LOAD_TIMEOUT, 16, cycles in LOAD_WAIT without ld_valid before abort; minimum 1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
ex_valid  in  1  execute has an instruction to retire.
ex_ready  out  1  wb_ctrl can accept; combinational, equals (state==IDLE).
ex_rd  in  5  destination register.
ex_reg_write  in  1  instruction writes rd.
ex_mem_to_reg  in  1  rd data comes from load unit.
ex_jal  in  1  JAL.
ex_jalr  in  1  JALR.
ex_alu_out  in  XLEN  ALU result / jump target.
ex_pc  in  XLEN  PC of instruction.
ld_valid  in  1  load data valid (one-cycle pulse).
ld_data  in  XLEN  load data.
rf_we  out  1  register-file write enable (one-cycle pulse).
rf_waddr  out  5  write address.
rf_wdata  out  XLEN  write data.
pc_redir  out  1  PC redirect pulse.
pc_target  out  XLEN  redirect target.
ld_timeout  out  1  load abort pulse.
retire_cnt  out  32  retired count (see Optional Feature).

Behaviour:
- Reset: state IDLE. rf_we, pc_redir and ld_timeout are 0. rf_waddr, rf_wdata, pc_target and retire_cnt are 0. The timeout counter is 0.
- rst in LOAD_WAIT drops the pending load; no write occurs.
- States: IDLE, LOAD_WAIT.
- Accept = ex_valid && ex_ready. Inputs are sampled on the accept edge.
- Decode priority: jump (jal||jalr) > mem_to_reg > reg_write > none.
- Jump:
  - Next cycle: pc_redir=1.
  - pc_target = ex_alu_out, with bit0 forced to 0 when jalr.
  - rf_we=(ex_rd!=0), rf_wdata=ex_pc+4 (mod 2^XLEN), rf_waddr=ex_rd.
  - Stays IDLE. jal and jalr both set is treated as jalr.
  - A jump with mem_to_reg also set ignores mem_to_reg.
- Load (mem_to_reg, no jump):
  - Go to LOAD_WAIT, latch rd, clear the counter. ex_ready=0.
  - In LOAD_WAIT, on ld_valid: next cycle rf_we=(rd!=0), rf_wdata=ld_data, then return to IDLE.
  - Otherwise the counter increments each cycle.
  - If the counter reaches LOAD_TIMEOUT-1 with no ld_valid: next cycle ld_timeout=1, no write, return to IDLE.
  - ld_valid in the same cycle as the timeout condition: data wins, no timeout.
  - The load is written even when ex_reg_write=0.
- ALU write (reg_write only): next cycle rf_we=(rd!=0), rf_wdata=ex_alu_out.
- None set: accepted, no outputs.
- x0: rd==0 never asserts rf_we; the instruction still retires.
- ld_valid in IDLE is ignored.
- Latency:
  - IDLE accept to outputs: 1 cycle.
  - Back-to-back ALU/jump accepts every cycle.
  - Load: ld_valid to rf_we is 1 cycle; ex_ready returns the cycle after ld_valid/timeout.
- rf_we, pc_redir and ld_timeout are single-cycle pulses. Data outputs hold their last value when not pulsed.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 on each completed retire (ALU, jump, load write, none-op, including rd==0). Timeouts are not counted. It wraps at 2^32 and clears on rst.
- Undefined: retire_cnt is tied to 0 and no counter logic is instantiated.

Decomposition:
- Package wb_pkg:
  - State enum {IDLE, LOAD_WAIT}.
  - PC_STEP=4, JALR_LSB_MASK, REG_ZERO=5'd0.
- Sub-module wb_load_timer: counter with clear, enable and expired outputs, parameterized by LOAD_TIMEOUT.

Test Plan:
- ALU write: rd=5, alu_out=0x1234, reg_write=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234, pc_redir=0.
- JALR redirect: ex_pc=0x100, alu_out=0x2003, jalr=1, rd=1 -> next cycle pc_redir=1, pc_target=0x2002, rf_we=1, wdata=0x104.
- Load wait: mem_to_reg, rd=7, ld_valid after 3 cycles with 0xDEADBEEF:
  - ex_ready=0 during the wait.
  - Cycle after ld_valid: rf_we=1, waddr=7, wdata=0xDEADBEEF.
  - ex_ready=1 the following cycle.
- Timeout: LOAD_TIMEOUT=4, no ld_valid -> ld_timeout pulse after 4 LOAD_WAIT cycles, no rf_we, back to IDLE. With the macro, retire_cnt unchanged.
- x0/boundary:
  - rd=0 JAL -> pc_redir=1, rf_we=0.
  - ld_valid on the exact timeout cycle -> write occurs, ld_timeout=0.
- Reset mid-load: rst while in LOAD_WAIT, then ld_valid -> no rf_we, all outputs 0, ex_ready=1.
